// File: rtl/usart_tx_engine_if.sv
// rtl/usart_tx_engine_if.sv - register-file side bundle of the USART transmitter
interface usart_tx_engine_if #(
  parameter int DATA_LEN = 8
);
  logic [DATA_LEN-1:0] wr_data;
  logic                wr_stb;
  logic                tx_en;
  logic [1:0]          par_mode;
  logic                stop2;
  logic                txc_clr;
  logic                udre;
  logic                txc;
  logic                busy;

  modport master (
    output wr_data, wr_stb, tx_en, par_mode, stop2, txc_clr,
    input  udre, txc, busy
  );

  modport slave (
    input  wr_data, wr_stb, tx_en, par_mode, stop2, txc_clr,
    output udre, txc, busy
  );
endinterface

// File: rtl/usart_tx_engine.sv
// rtl/usart_tx_engine.sv - USART transmitter: UDR holding register plus start/data/parity/stop serialiser
module usart_tx_engine #(
  parameter int DATA_LEN = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  usart_tx_engine_if.slave  bus,
  output logic              txd
);
  localparam int CW = 4;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] hold_q, hold_d;
  logic [DATA_LEN-1:0] shift_q, shift_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                udre_q, udre_d;
  logic                txc_q, txc_d;
  logic                txd_q, txd_d;
  logic                par_en_q, par_en_d;
  logic                par_bit_q, par_bit_d;
  logic                stop2_q, stop2_d;
  logic                load_ok, load, frame_end, txc_set;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    udre_d    = udre_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop2_d   = stop2_q;
    load      = 1'b0;
    frame_end = 1'b0;
    txc_set   = 1'b0;
    load_ok   = !udre_q && bus.tx_en;

    if (bus.wr_stb && udre_q) begin
      hold_d = bus.wr_data;
      udre_d = 1'b0;
    end

    if (en) begin
      case (state_q)
        IDLE:   load = load_ok;
        START: begin
          state_d = DATA;
          cnt_d   = '0;
        end
        DATA: begin
          shift_d = shift_q >> 1;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_LEN - 1)) state_d = par_en_q ? PARITY : STOP1;
        end
        PARITY: state_d = STOP1;
        STOP1: begin
          if (stop2_q) state_d = STOP2;
          else         frame_end = 1'b1;
        end
        STOP2:   frame_end = 1'b1;
        default: state_d = IDLE;
      endcase
    end

    // A waiting byte chains straight into the next start bit with no idle gap.
    if (frame_end) begin
      if (load_ok) begin
        load = 1'b1;
      end else begin
        state_d = IDLE;
        txc_set = 1'b1;
      end
    end

    if (load) begin
      state_d   = START;
      shift_d   = hold_q;
      par_bit_d = (^hold_q) ^ bus.par_mode[0];
      par_en_d  = bus.par_mode[1];
      stop2_d   = bus.stop2;
      udre_d    = 1'b1;
    end

    txc_d = txc_q;
    if (bus.txc_clr) txc_d = 1'b0;
    if (txc_set)     txc_d = 1'b1;

    // txd is registered from the next state so each bit spans one full en period.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = par_bit_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      udre_q    <= 1'b1;
      txc_q     <= 1'b0;
      txd_q     <= 1'b1;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      udre_q    <= udre_d;
      txc_q     <= txc_d;
      txd_q     <= txd_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop2_q   <= stop2_d;
    end
  end

  assign txd      = txd_q;
  assign bus.udre = udre_q;
  assign bus.txc  = txc_q;
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_usart_tx_engine.sv
// tb/tb_usart_tx_engine.sv - bench for usart_tx_engine: frame-level model, directed frames, random traffic
module tb_usart_tx_engine;
  logic clk = 1'b0;
  logic nrst;
  logic en;
  logic txd;

  usart_tx_engine_if #(.DATA_LEN(8)) bus ();

  usart_tx_engine #(.DATA_LEN(8)) dut (
    .clk  (clk),
    .nrst (nrst),
    .en   (en),
    .bus  (bus),
    .txd  (txd)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic chk_on = 1'b0;
  logic [31:0] cap;

  // Frame-level model: a queue of the bits still to be sent for the frame in flight.
  bit       q[$];
  logic     m_full, m_txc, m_busy, m_txd, m_do_wr, m_set_txc;
  logic [7:0] m_hold;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_full = 1'b0; m_hold = 8'h00; m_txc = 1'b0; m_busy = 1'b0; m_txd = 1'b1;
      q.delete();
    end else begin
      m_do_wr   = bus.wr_stb && !m_full;
      m_set_txc = 1'b0;
      if (en) begin
        if (q.size() > 0) begin
          m_txd = q.pop_front();
        end else if (m_full && bus.tx_en) begin
          q.push_back(1'b0);
          for (int i = 0; i < 8; i++) q.push_back(m_hold[i]);
          if (bus.par_mode[1]) q.push_back((^m_hold) ^ bus.par_mode[0]);
          q.push_back(1'b1);
          if (bus.stop2) q.push_back(1'b1);
          m_full = 1'b0;
          m_busy = 1'b1;
          m_txd  = q.pop_front();
        end else begin
          if (m_busy) m_set_txc = 1'b1;
          m_busy = 1'b0;
          m_txd  = 1'b1;
        end
      end
      if (m_do_wr) begin
        m_full = 1'b1;
        m_hold = bus.wr_data;
      end
      if (bus.txc_clr) m_txc = 1'b0;
      if (m_set_txc)   m_txc = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      n_total++;
      if (txd !== m_txd || bus.udre !== !m_full || bus.txc !== m_txc || bus.busy !== m_busy)
        $display("FAIL model_cycle t=%0t txd=%b exp=%b udre=%b exp=%b txc=%b exp=%b busy=%b exp=%b",
                 $time, txd, m_txd, bus.udre, !m_full, bus.txc, m_txc, bus.busy, m_busy);
      else
        n_pass++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", name, act, exp);
  endtask

  task automatic cyc(input logic e);
    en = e;
    @(posedge clk);
    #1;
    en = 1'b0;
    bus.wr_stb  = 1'b0;
    bus.txc_clr = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    bus.wr_data = d;
    bus.wr_stb  = 1'b1;
    cyc(1'b0);
  endtask

  // One bit period = 16 clocks starting with an en; txd is sampled mid-period.
  task automatic run_bits(input int from, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1);
      repeat (7) cyc(1'b0);
      cap[from + i] = txd;
      repeat (8) cyc(1'b0);
    end
  endtask

  task automatic send(input logic [7:0] d, input int nb);
    cap = '0;
    wr(d);
    run_bits(0, nb);
    cyc(1'b1);
  endtask

  initial begin
    nrst = 1'b0; en = 1'b0;
    bus.wr_data = '0; bus.wr_stb = 1'b0; bus.tx_en = 1'b1;
    bus.par_mode = 2'b00; bus.stop2 = 1'b0; bus.txc_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", txd, 1);
    chk("rst_udre", bus.udre, 1);
    chk("rst_txc", bus.txc, 0);
    chk("rst_busy", bus.busy, 0);
    nrst = 1'b1;
    chk_on = 1'b1;

    // Basic 8N1 frame of 0x55.
    cap = '0;
    wr(8'h55);
    chk("udre_after_wr", bus.udre, 0);
    cyc(1'b1);
    chk("udre_after_load", bus.udre, 1);
    cap[0] = txd;
    repeat (15) cyc(1'b0);
    run_bits(1, 9);
    chk("txc_before_end", bus.txc, 0);
    cyc(1'b1);
    chk("frame_55", cap[9:0], 32'h2AA);
    chk("txc_after_55", bus.txc, 1);
    chk("busy_after_55", bus.busy, 0);

    // Parity frames, 11 bit periods each.
    bus.par_mode = 2'b10; send(8'h03, 11); chk("even_03", cap[10:0], 32'h406);
    bus.par_mode = 2'b11; send(8'h03, 11); chk("odd_03",  cap[10:0], 32'h606);
    bus.par_mode = 2'b10; send(8'h07, 11); chk("even_07", cap[10:0], 32'h60E);
    bus.par_mode = 2'b00;

    // txc_clr alone, then set and clear colliding on the same cycle.
    bus.txc_clr = 1'b1; cyc(1'b0);
    chk("txc_clr_alone", bus.txc, 0);
    cap = '0;
    wr(8'h81);
    run_bits(0, 10);
    bus.txc_clr = 1'b1;
    cyc(1'b1);
    chk("txc_set_wins", bus.txc, 1);
    chk("frame_81", cap[9:0], {22'd0, 1'b1, 8'h81, 1'b0});
    bus.txc_clr = 1'b1; cyc(1'b0);

    // Back-to-back frames with two stop bits.
    bus.stop2 = 1'b1;
    cap = '0;
    wr(8'hA5);
    run_bits(0, 3);
    wr(8'h3C);
    run_bits(3, 19);
    chk("b2b_txc_between", bus.txc, 0);
    cyc(1'b1);
    chk("b2b_frames", cap[21:0], {10'd0, 2'b11, 8'h3C, 1'b0, 2'b11, 8'hA5, 1'b0});
    chk("b2b_txc_end", bus.txc, 1);
    bus.stop2 = 1'b0;

    // Write while full is dropped.
    cap = '0;
    wr(8'h11);
    wr(8'h22);
    chk("udre_full", bus.udre, 0);
    run_bits(0, 10);
    cyc(1'b1);
    chk("ignored_wr", cap[9:0], {22'd0, 1'b1, 8'h11, 1'b0});

    // tx_en low holds the byte until re-enabled.
    bus.tx_en = 1'b0;
    wr(8'h5A);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1);
      repeat (3) cyc(1'b0);
    end
    chk("txen0_txd", txd, 1);
    chk("txen0_udre", bus.udre, 0);
    bus.tx_en = 1'b1;
    cap = '0;
    run_bits(0, 10);
    cyc(1'b1);
    chk("txen_resume", cap[9:0], {22'd0, 1'b1, 8'h5A, 1'b0});

    // Asynchronous reset during data bit 3 of 0xF0.
    cap = '0;
    wr(8'hF0);
    run_bits(0, 4);
    cyc(1'b1);
    repeat (3) cyc(1'b0);
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_busy", bus.busy, 1);
    nrst = 1'b0;
    #1;
    chk("midrst_txd", txd, 1);
    chk("midrst_udre", bus.udre, 1);
    chk("midrst_busy", bus.busy, 0);
    repeat (2) cyc(1'b0);
    nrst = 1'b1;
    send(8'h0F, 10);
    chk("post_rst_0f", cap[9:0], {22'd0, 1'b1, 8'h0F, 1'b0});

    // Random traffic checked cycle by cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      bus.wr_stb  = ($urandom_range(0, 7) == 0);
      bus.wr_data = 8'($urandom);
      bus.txc_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0) bus.tx_en = ~bus.tx_en;
      if ($urandom_range(0, 49) == 0) bus.par_mode = 2'($urandom);
      if ($urandom_range(0, 49) == 0) bus.stop2 = 1'($urandom);
      cyc($urandom_range(0, 3) == 0);
    end
    bus.tx_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b1);
      cyc(1'b0);
    end
    chk("final_busy", bus.busy, 0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
